// File: rtl/fill_sched_pkg.sv
// Shared types and limits for the rectangle fill scheduler.
package fill_sched_pkg;

   localparam int unsigned XW = 9;
   localparam int unsigned YW = 8;

   localparam logic [XW-1:0] X_MAX_DEFAULT = 9'd319;
   localparam logic [YW-1:0] Y_MAX_DEFAULT = 8'd199;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [XW-1:0] x1;
      logic [YW-1:0] y1;
      logic [XW-1:0] x2;
      logic [YW-1:0] y2;
      logic          value;
   } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; exactly one ready is offered while enabled.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic valid0_i,
   input  logic valid1_i,
   output logic ready0_o,
   output logic ready1_o,
   output logic grant_o,
   output logic fire_o
);

   logic last_grant_q;
   logic gnt;

   // A lone valid requester wins; otherwise the one not granted last.
   always_comb begin
      gnt = ~last_grant_q;
      if (valid0_i && !valid1_i) begin
         gnt = 1'b0;
      end else if (valid1_i && !valid0_i) begin
         gnt = 1'b1;
      end
      grant_o  = gnt;
      ready0_o = en_i && !gnt;
      ready1_o = en_i && gnt;
      fire_o   = (en_i && !gnt && valid0_i) || (en_i && gnt && valid1_i);
   end

   // Remember the last granted requester; reset favours req0 on the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (fire_o) begin
         last_grant_q <= gnt;
      end
   end

endmodule

// File: rtl/fill_scheduler.sv
// Fill command scheduler: arbitrate, check/clip, issue, track busy, respond.
module fill_scheduler
   import fill_sched_pkg::*;
#(
   parameter logic [XW-1:0] X_MAX       = X_MAX_DEFAULT,
   parameter logic [YW-1:0] Y_MAX       = Y_MAX_DEFAULT,
   parameter int unsigned   ACK_TIMEOUT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [XW-1:0] req0_x1,
   input  logic [XW-1:0] req0_x2,
   input  logic [YW-1:0] req0_y1,
   input  logic [YW-1:0] req0_y2,
   input  logic          req0_value,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [XW-1:0] req1_x1,
   input  logic [XW-1:0] req1_x2,
   input  logic [YW-1:0] req1_y1,
   input  logic [YW-1:0] req1_y2,
   input  logic          req1_value,
   output logic [XW-1:0] fill_x1,
   output logic [XW-1:0] fill_x2,
   output logic [YW-1:0] fill_y1,
   output logic [YW-1:0] fill_y2,
   output logic          fill_value,
   output logic          start_fill,
   input  logic          fill_busy,
   output logic          done,
   output logic          done_id,
   output logic          done_error
);

   localparam int unsigned   CW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

   state_e        state_q;
   cmd_t          cmd_q;
   cmd_t          cmd0;
   cmd_t          cmd1;
   logic          id_q;
   logic [CW-1:0] ack_cnt_q;
   logic          idle;
   logic          grant;
   logic          fire;
   logic          reject;
   logic [XW-1:0] x2_clip;
   logic [YW-1:0] y2_clip;

   logic [XW-1:0] fill_x1_q;
   logic [XW-1:0] fill_x2_q;
   logic [YW-1:0] fill_y1_q;
   logic [YW-1:0] fill_y2_q;
   logic          fill_value_q;
   logic          start_fill_q;
   logic          done_q;
   logic          done_id_q;
   logic          done_error_q;

   assign idle = (state_q == ST_IDLE);
   assign cmd0 = '{x1: req0_x1, y1: req0_y1, x2: req0_x2, y2: req0_y2, value: req0_value};
   assign cmd1 = '{x1: req1_x1, y1: req1_y1, x2: req1_x2, y2: req1_y2, value: req1_value};

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (reset),
      .en_i     (idle),
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .ready0_o (req0_ready),
      .ready1_o (req1_ready),
      .grant_o  (grant),
      .fire_o   (fire)
   );

   // Legality check and clipping of the latched command against the framebuffer.
   always_comb begin
      reject  = (cmd_q.x1 > cmd_q.x2) || (cmd_q.y1 > cmd_q.y2) ||
                (cmd_q.x1 > X_MAX)    || (cmd_q.y1 > Y_MAX);
      x2_clip = (cmd_q.x2 > X_MAX) ? X_MAX : cmd_q.x2;
      y2_clip = (cmd_q.y2 > Y_MAX) ? Y_MAX : cmd_q.y2;
   end

   // Command FSM with registered engine and completion outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cmd_q        <= '0;
         id_q         <= 1'b0;
         ack_cnt_q    <= '0;
         fill_x1_q    <= '0;
         fill_x2_q    <= '0;
         fill_y1_q    <= '0;
         fill_y2_q    <= '0;
         fill_value_q <= 1'b0;
         start_fill_q <= 1'b0;
         done_q       <= 1'b0;
         done_id_q    <= 1'b0;
         done_error_q <= 1'b0;
      end else begin
         start_fill_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fire) begin
                  cmd_q   <= grant ? cmd1 : cmd0;
                  id_q    <= grant;
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (reject) begin
                  done_q       <= 1'b1;
                  done_id_q    <= id_q;
                  done_error_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  // Outputs load on entry to ISSUE so start_fill and coordinates coincide.
                  fill_x1_q    <= cmd_q.x1;
                  fill_y1_q    <= cmd_q.y1;
                  fill_x2_q    <= x2_clip;
                  fill_y2_q    <= y2_clip;
                  fill_value_q <= cmd_q.value;
                  start_fill_q <= 1'b1;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ack_cnt_q <= '0;
               state_q   <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (fill_busy) begin
                  state_q <= ST_WAIT_DONE;
               end else if (ack_cnt_q == ACK_LAST) begin
                  // Counter would reach ACK_TIMEOUT on this increment.
                  done_q       <= 1'b1;
                  done_id_q    <= id_q;
                  done_error_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  ack_cnt_q <= ack_cnt_q + CW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!fill_busy) begin
                  done_q       <= 1'b1;
                  done_id_q    <= id_q;
                  done_error_q <= 1'b0;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               done_id_q    <= 1'b0;
               done_error_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fill_x1    = fill_x1_q;
   assign fill_x2    = fill_x2_q;
   assign fill_y1    = fill_y1_q;
   assign fill_y2    = fill_y2_q;
   assign fill_value = fill_value_q;
   assign start_fill = start_fill_q;
   assign done       = done_q;
   assign done_id    = done_id_q;
   assign done_error = done_error_q;

endmodule

// File: tb/tb_fill_scheduler.sv
// Directed self-checking bench for fill_scheduler.
module tb_fill_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [8:0] req0_x1, req0_x2, req1_x1, req1_x2;
   logic [7:0] req0_y1, req0_y2, req1_y1, req1_y2;
   logic       req0_value, req1_value;
   logic [8:0] fill_x1, fill_x2;
   logic [7:0] fill_y1, fill_y2;
   logic       fill_value, start_fill, fill_busy;
   logic       done, done_id, done_error;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fill_scheduler #(
      .X_MAX       (9'd319),
      .Y_MAX       (8'd199),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x1    (req0_x1),
      .req0_x2    (req0_x2),
      .req0_y1    (req0_y1),
      .req0_y2    (req0_y2),
      .req0_value (req0_value),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x1    (req1_x1),
      .req1_x2    (req1_x2),
      .req1_y1    (req1_y1),
      .req1_y2    (req1_y2),
      .req1_value (req1_value),
      .fill_x1    (fill_x1),
      .fill_x2    (fill_x2),
      .fill_y1    (fill_y1),
      .fill_y2    (fill_y2),
      .fill_value (fill_value),
      .start_fill (start_fill),
      .fill_busy  (fill_busy),
      .done       (done),
      .done_id    (done_id),
      .done_error (done_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [8:0] x1, input logic [7:0] y1,
                          input logic [8:0] x2, input logic [7:0] y2, input logic v);
      if (r == 0) begin
         req0_x1 = x1; req0_y1 = y1; req0_x2 = x2; req0_y2 = y2; req0_value = v; req0_valid = 1'b1;
      end else begin
         req1_x1 = x1; req1_y1 = y1; req1_x2 = x2; req1_y2 = y2; req1_value = v; req1_valid = 1'b1;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_fill"}, {fill_x1, fill_x2, fill_y1, fill_y2, fill_value}, 0);
      check({tag, "_start"}, start_fill, 0);
      check({tag, "_done"}, {done, done_id, done_error}, 0);
   endtask

   // Returns with the current cycle being the handshake cycle.
   task automatic wait_hs(output int id, output int waited);
      id = -1;
      waited = 0;
      while (id < 0 && waited < 20) begin
         if (req0_valid && req0_ready) id = 0;
         else if (req1_valid && req1_ready) id = 1;
         else begin
            tick();
            waited++;
         end
      end
      if (id < 0) check("hs_timeout", 1, 0);
   endtask

   task automatic drop_valid(input int id);
      if (id == 0) req0_valid = 1'b0;
      else if (id == 1) req1_valid = 1'b0;
   endtask

   // Full valid command; returns in the done (RESP) cycle.
   task automatic do_cmd(input string tag, input int exp_id,
                         input logic [8:0] ex1, input logic [7:0] ey1,
                         input logic [8:0] ex2, input logic [7:0] ey2, input logic ev,
                         input int ack_dly, input int busy_len, input bit drop);
      int id, waited;
      bit early;
      wait_hs(id, waited);
      check({tag, "_grant"}, id, exp_id);
      tick();
      if (drop) drop_valid(id);
      check({tag, "_ready_in_check"}, {req0_ready, req1_ready}, 0);
      check({tag, "_start_early"}, start_fill, 0);
      tick();
      check({tag, "_start"}, start_fill, 1);
      check({tag, "_coords"}, {fill_x1, fill_y1, fill_x2, fill_y2, fill_value},
            {ex1, ey1, ex2, ey2, ev});
      early = 1'b0;
      for (int c = 1; c <= ack_dly + busy_len; c++) begin
         tick();
         fill_busy = (c >= ack_dly) && (c < ack_dly + busy_len);
         if (done || start_fill) early = 1'b1;
      end
      tick();
      fill_busy = 1'b0;
      check({tag, "_no_early_done"}, early, 0);
      check({tag, "_done"}, {done, done_id, done_error}, {1'b1, exp_id[0], 1'b0});
   endtask

   // Rejected command; returns in the RESP cycle.
   task automatic do_reject(input string tag, input int exp_id, input int exp_wait);
      int id, waited;
      wait_hs(id, waited);
      check({tag, "_grant"}, id, exp_id);
      check({tag, "_spacing"}, waited, exp_wait);
      tick();
      check({tag, "_no_start_chk"}, start_fill, 0);
      tick();
      check({tag, "_done"}, {done, done_id, done_error, start_fill},
            {1'b1, exp_id[0], 1'b1, 1'b0});
   endtask

   logic [8:0] rj_x1 [4] = '{9'd50, 9'd320, 9'd0,  9'd0};
   logic [8:0] rj_x2 [4] = '{9'd40, 9'd400, 9'd0,  9'd0};
   logic [7:0] rj_y1 [4] = '{8'd0,  8'd0,   8'd200, 8'd50};
   logic [7:0] rj_y2 [4] = '{8'd0,  8'd0,   8'd210, 8'd40};

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int id, waited;
      bit early;

      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_x1 = '0; req0_x2 = '0; req0_y1 = '0; req0_y2 = '0; req0_value = 1'b0;
      req1_x1 = '0; req1_x2 = '0; req1_y1 = '0; req1_y2 = '0; req1_value = 1'b0;
      fill_busy = 1'b0;
      repeat (3) tick();
      check_outputs_zero("rst");
      check("rst_ready", {req0_ready, req1_ready}, 2'b10);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_outputs_zero("post_rst");
      check("post_rst_ready", {req0_ready, req1_ready}, 2'b10);

      // Single command from req0, engine busy for 5 cycles.
      set_req(0, 9'd10, 8'd20, 9'd30, 8'd40, 1'b1);
      do_cmd("single", 0, 9'd10, 8'd20, 9'd30, 8'd40, 1'b1, 1, 5, 1'b1);
      tick();
      check("single_done_pulse", done, 0);
      check("single_hold", {fill_x1, fill_x2}, {9'd10, 9'd30});

      // Rejects from req1 back to back.
      for (int i = 0; i < 4; i++) begin
         set_req(1, rj_x1[i], rj_y1[i], rj_x2[i], rj_y2[i], 1'b1);
         do_reject($sformatf("reject%0d", i), 1, (i == 0) ? 0 : 1);
      end
      req1_valid = 1'b0;
      check("reject_hold", {fill_x1, fill_y1, fill_x2, fill_y2}, {9'd10, 8'd20, 9'd30, 8'd40});

      // Both requesters valid continuously: grants alternate.
      set_req(0, 9'd1, 8'd2, 9'd3, 8'd4, 1'b1);
      set_req(1, 9'd5, 8'd6, 9'd7, 8'd8, 1'b0);
      do_cmd("rr0", 0, 9'd1, 8'd2, 9'd3, 8'd4, 1'b1, 1, 1, 1'b0);
      do_cmd("rr1", 1, 9'd5, 8'd6, 9'd7, 8'd8, 1'b0, 2, 1, 1'b0);
      do_cmd("rr2", 0, 9'd1, 8'd2, 9'd3, 8'd4, 1'b1, 1, 2, 1'b0);
      do_cmd("rr3", 1, 9'd5, 8'd6, 9'd7, 8'd8, 1'b0, 4, 1, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Clipping at the framebuffer edge.
      set_req(0, 9'd300, 8'd190, 9'd511, 8'd255, 1'b0);
      do_cmd("clip", 0, 9'd300, 8'd190, 9'd319, 8'd199, 1'b0, 2, 3, 1'b1);

      // Engine never acknowledges.
      set_req(1, 9'd0, 8'd0, 9'd5, 8'd5, 1'b1);
      wait_hs(id, waited);
      check("tmo_grant", id, 1);
      tick();
      drop_valid(id);
      tick();
      check("tmo_start", start_fill, 1);
      early = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (done) early = 1'b1;
      end
      check("tmo_no_early_done", early, 0);
      tick();
      check("tmo_done", {done, done_id, done_error}, 3'b111);
      set_req(0, 9'd7, 8'd7, 9'd9, 8'd9, 1'b1);
      do_cmd("after_tmo", 0, 9'd7, 8'd7, 9'd9, 8'd9, 1'b1, 3, 2, 1'b1);

      // Reset while the engine is busy.
      set_req(0, 9'd20, 8'd30, 9'd40, 8'd50, 1'b1);
      wait_hs(id, waited);
      check("rstmid_grant", id, 0);
      tick();
      drop_valid(id);
      tick();
      check("rstmid_start", start_fill, 1);
      tick();
      fill_busy = 1'b1;
      tick();
      tick();
      check("rstmid_in_fill", {done, start_fill}, 0);
      #2;
      reset = 1'b0;
      #1;
      check_outputs_zero("rstmid");
      check("rstmid_ready", {req0_ready, req1_ready}, 2'b10);
      @(negedge clk);
      reset = 1'b1;
      fill_busy = 1'b0;
      tick();
      set_req(0, 9'd11, 8'd12, 9'd13, 8'd14, 1'b0);
      set_req(1, 9'd15, 8'd16, 9'd17, 8'd18, 1'b1);
      check("rstmid_tie_ready", {req0_ready, req1_ready}, 2'b10);
      do_cmd("rstmid_tie", 0, 9'd11, 8'd12, 9'd13, 8'd14, 1'b0, 1, 1, 1'b1);
      do_cmd("rstmid_next", 1, 9'd15, 8'd16, 9'd17, 8'd18, 1'b1, 1, 1, 1'b1);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
